// File: rtl/nary_join_adder_pkg.sv
// nary_join_adder_pkg
// Shared types, constants and helper functions for the N-way join adder.
//   clog2_min1 : ceil(log2(n)), never less than 1
//   buf_cnt_t  : occupancy count of the 2-entry output buffer
//   SAT_CNT_W  : width of the saturation event counter
//   sat_clamp  : clamps a 64-bit sum to a width-bit signed/unsigned range
package nary_join_adder_pkg;

  localparam int SAT_CNT_W = 16;

  typedef logic [1:0] buf_cnt_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  // sum is interpreted as two's complement when signed_mode is set,
  // otherwise as an unsigned value.
  function automatic logic [63:0] sat_clamp(input logic [63:0] sum,
                                            input int          width,
                                            input bit          signed_mode);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic        [63:0] umax;
    s    = signed'(sum);
    hi   = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (width - 1));
    umax = (64'd1 << width) - 64'd1;
    if (signed_mode) begin
      if (s > hi) return hi;
      if (s < lo) return lo;
      return sum;
    end
    if (sum > umax) return umax;
    return sum;
  endfunction

endpackage

// File: rtl/nary_join_adder_tree.sv
// nary_join_adder_tree
// Combinational adder: extends each of N_IN operands to OWIDTH (sign- or
// zero-extension depending on SIGNED) and sums them exactly.
//   ldata : packed operands, channel i at [i*WIDTH +: WIDTH]
//   sum   : exact OWIDTH-bit sum
module nary_join_adder_tree
  import nary_join_adder_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int WIDTH  = 10,
  parameter int SIGNED = 1,
  parameter int OWIDTH = WIDTH + clog2_min1(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] ldata,
  output logic [OWIDTH-1:0]     sum
);

  logic [OWIDTH-1:0] ext [N_IN];

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_ext
      if (SIGNED != 0) begin : g_sext
        assign ext[gi] = {{(OWIDTH-WIDTH){ldata[gi*WIDTH+WIDTH-1]}},
                          ldata[gi*WIDTH +: WIDTH]};
      end else begin : g_zext
        assign ext[gi] = {{(OWIDTH-WIDTH){1'b0}}, ldata[gi*WIDTH +: WIDTH]};
      end
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) sum = sum + ext[i];
  end

endmodule

// File: rtl/nary_join_adder.sv
// nary_join_adder
// Joins N_IN valid/ready operand channels, sums the operands and buffers the
// result in a 2-entry FIFO presented on a single valid/ready output.
// Compile-time option: NARY_JOIN_ADDER_SATURATE_EN clamps each sum to the
// WIDTH-bit range before buffering and counts clamps in sat_cnt.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   lvalid  : per-channel operand valid   lready : per-channel operand ready
//   ldata   : packed operands             rvalid/rready/rdata : result channel
//   sat_cnt : number of saturated results (sticky at all-ones)
module nary_join_adder
  import nary_join_adder_pkg::*;
#(
  parameter  int N_IN   = 4,
  parameter  int WIDTH  = 10,
  parameter  int SIGNED = 1,
  localparam int OWIDTH = WIDTH + clog2_min1(N_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN-1:0]      lvalid,
  output logic [N_IN-1:0]      lready,
  input  logic [N_IN*WIDTH-1:0] ldata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [OWIDTH-1:0]    rdata,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  logic [OWIDTH-1:0] sum;
  logic [OWIDTH-1:0] wr_val;
  logic              fire;
  logic              pop;

  nary_join_adder_tree #(
    .N_IN   (N_IN),
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED),
    .OWIDTH (OWIDTH)
  ) u_tree (
    .ldata (ldata),
    .sum   (sum)
  );

`ifdef NARY_JOIN_ADDER_SATURATE_EN
  logic        sign_bit;
  logic [63:0] sum_ext;
  logic [63:0] clamped;
  logic        sat_hit;

  assign sign_bit = (SIGNED != 0) && sum[OWIDTH-1];
  assign sum_ext  = {{(64-OWIDTH){sign_bit}}, sum};
  assign clamped  = sat_clamp(sum_ext, WIDTH, SIGNED != 0);
  assign sat_hit  = (clamped != sum_ext);
  assign wr_val   = clamped[OWIDTH-1:0];
`else
  assign wr_val   = sum;
`endif

  // Output buffer state
  buf_cnt_t          count_reg;
  buf_cnt_t          count_next;
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [OWIDTH-1:0] mem [2];

  // rst gates fire so that lready stays low for the whole reset interval.
  // Only registered state feeds fire: no rready -> lready path.
  assign fire   = rst && (&lvalid) && (count_reg != 2'd2);
  assign lready = {N_IN{fire}};
  assign rvalid = (count_reg != 2'd0);
  assign pop    = rvalid && rready;
  assign rdata  = rvalid ? mem[rd_ptr_reg] : '0;

  always_comb begin
    count_next = count_reg;
    case ({fire, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg  <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (fire) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Storage needs no reset: rdata is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (fire) mem[wr_ptr_reg] <= wr_val;
  end

`ifdef NARY_JOIN_ADDER_SATURATE_EN
  logic [SAT_CNT_W-1:0] sat_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt_reg <= '0;
    end else if (fire && sat_hit && (sat_cnt_reg != '1)) begin
      sat_cnt_reg <= sat_cnt_reg + 1'b1;
    end
  end

  assign sat_cnt = sat_cnt_reg;
`else
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_nary_join_adder.sv
module tb_nary_join_adder;

  localparam int N_IN   = 4;
  localparam int WIDTH  = 10;
  localparam int SIGNED = 1;
  localparam int OWIDTH = WIDTH + $clog2(N_IN);
`ifdef NARY_JOIN_ADDER_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef logic [N_IN-1:0][WIDTH-1:0] ops_t;

  logic                  clk;
  logic                  rst;
  logic [N_IN-1:0]       lvalid;
  logic [N_IN-1:0]       lready;
  logic [N_IN*WIDTH-1:0] ldata;
  logic                  rvalid;
  logic                  rready;
  logic [OWIDTH-1:0]     rdata;
  logic [15:0]           sat_cnt;

  int total = 0;
  int bad   = 0;

  nary_join_adder #(
    .N_IN   (N_IN),
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .lvalid  (lvalid),
    .lready  (lready),
    .ldata   (ldata),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .sat_cnt (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int op_int(input logic [WIDTH-1:0] v);
    if (SIGNED != 0) return int'(signed'(v));
    return int'(v);
  endfunction

  function automatic int exact_sum(input ops_t o);
    int s;
    s = 0;
    for (int i = 0; i < N_IN; i++) s += op_int(o[i]);
    return s;
  endfunction

  function automatic int clamp_val(input int s);
    int lo;
    int hi;
    if (!SAT_EN) return s;
    if (SIGNED != 0) begin
      lo = -(1 << (WIDTH - 1));
      hi = (1 << (WIDTH - 1)) - 1;
    end else begin
      lo = 0;
      hi = (1 << WIDTH) - 1;
    end
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic logic [OWIDTH-1:0] exp_rdata(input ops_t o);
    return OWIDTH'(clamp_val(exact_sum(o)));
  endfunction

  function automatic bit exp_sat(input ops_t o);
    return clamp_val(exact_sum(o)) != exact_sum(o);
  endfunction

  function automatic ops_t rand_ops();
    ops_t o;
    for (int i = 0; i < N_IN; i++) o[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    return o;
  endfunction

  // ---------------- timing helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    lvalid = '0;
    rready = 1'b0;
    rst    = 1'b0;
    #2;
    rst    = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ops_t o;
    cycle();
    o = rand_ops();
    ldata = o; lvalid = '1; rready = 1'b1; rst = 1'b0;
    #1;
    total++; if (lready !== '0) begin bad++; $display("FAIL reset_lready: got %b want 0", lready); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %0h want 0", rdata); end
    total++; if (sat_cnt !== 16'd0) begin bad++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
    cycle();
    total++; if (lready !== '0 || rvalid !== 1'b0) begin bad++; $display("FAIL reset_held: lready=%b rvalid=%b want 0/0", lready, rvalid); end
    rst = 1'b1;
    #1;
    total++; if (lready !== '1) begin bad++; $display("FAIL reset_release_lready: got %b want %b", lready, {N_IN{1'b1}}); end
    cycle();
    lvalid = '0;
    #1;
    total++; if (rvalid !== 1'b1 || rdata !== exp_rdata(o)) begin bad++; $display("FAIL reset_first_fire: rvalid=%b rdata=%0h want 1/%0h", rvalid, rdata, exp_rdata(o)); end
    cycle();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_drain: rvalid=%b want 0", rvalid); end
    $display("txn reset: first fire after release, rdata=%0h", exp_rdata(o));
  endtask

  task automatic test_basic();
    ops_t o;
    o[0] = WIDTH'(100); o[1] = WIDTH'(-50); o[2] = WIDTH'(7); o[3] = WIDTH'(3);
    rready = 1'b1; ldata = o; lvalid = '1;
    #1;
    total++; if (lready !== '1) begin bad++; $display("FAIL basic_lready: got %b want all ones", lready); end
    cycle();
    lvalid = '0;
    #1;
    total++; if (rvalid !== 1'b1 || rdata !== 12'd60) begin bad++; $display("FAIL basic_sum: rvalid=%b rdata=%0d want 1/60", rvalid, rdata); end
    cycle();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL basic_drain: rvalid=%b want 0", rvalid); end
    $display("txn basic: 100-50+7+3 rdata=%0d", $signed(rdata));
  endtask

  task automatic test_hold_channel();
    ops_t o;
    o = rand_ops();
    rready = 1'b1; ldata = o; lvalid = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (lready !== '0 || rvalid !== 1'b0) begin bad++; $display("FAIL hold_wait%0d: lready=%b rvalid=%b want 0/0", k, lready, rvalid); end
      cycle();
    end
    lvalid = '1;
    #1;
    total++; if (lready !== '1) begin bad++; $display("FAIL hold_join: lready=%b want all ones", lready); end
    cycle();
    lvalid = '0;
    #1;
    total++; if (rvalid !== 1'b1 || rdata !== exp_rdata(o)) begin bad++; $display("FAIL hold_result: rvalid=%b rdata=%0h want 1/%0h", rvalid, rdata, exp_rdata(o)); end
    cycle();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL hold_single_fire: rvalid=%b want 0", rvalid); end
    $display("txn hold: single fire rdata=%0h", exp_rdata(o));
  endtask

  task automatic test_backpressure();
    ops_t a, b, c;
    a = rand_ops(); b = rand_ops(); c = rand_ops();
    rready = 1'b0; ldata = a; lvalid = '1;
    #1;
    total++; if (lready !== '1) begin bad++; $display("FAIL bp_accept_a: lready=%b want all ones", lready); end
    cycle();
    ldata = b;
    #1;
    total++; if (lready !== '1 || rvalid !== 1'b1 || rdata !== exp_rdata(a)) begin bad++; $display("FAIL bp_accept_b: lready=%b rvalid=%b rdata=%0h want 1s/1/%0h", lready, rvalid, rdata, exp_rdata(a)); end
    cycle();
    ldata = c;
    #1;
    total++; if (lready !== '0) begin bad++; $display("FAIL bp_full: lready=%b want 0", lready); end
    cycle();
    total++; if (lready !== '0 || rdata !== exp_rdata(a)) begin bad++; $display("FAIL bp_full_hold: lready=%b rdata=%0h want 0/%0h", lready, rdata, exp_rdata(a)); end
    rready = 1'b1;
    #1;
    total++; if (lready !== '0) begin bad++; $display("FAIL bp_no_comb_path: lready=%b want 0", lready); end
    cycle();
    total++; if (rdata !== exp_rdata(b) || lready !== '1) begin bad++; $display("FAIL bp_pop_a: rdata=%0h lready=%b want %0h/all ones", rdata, lready, exp_rdata(b)); end
    cycle();
    lvalid = '0;
    #1;
    total++; if (rvalid !== 1'b1 || rdata !== exp_rdata(c)) begin bad++; $display("FAIL bp_third: rvalid=%b rdata=%0h want 1/%0h", rvalid, rdata, exp_rdata(c)); end
    cycle();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL bp_drain: rvalid=%b want 0", rvalid); end
    $display("txn backpressure: order %0h %0h %0h", exp_rdata(a), exp_rdata(b), exp_rdata(c));
  endtask

  task automatic test_stream();
    ops_t o;
    logic [OWIDTH-1:0] exp;
    rready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      o = rand_ops();
      ldata = o; lvalid = '1;
      #1;
      total++; if (lready !== '1) begin bad++; $display("FAIL stream_lready%0d: got %b want all ones", k, lready); end
      exp = exp_rdata(o);
      cycle();
      total++; if (rvalid !== 1'b1 || rdata !== exp) begin bad++; $display("FAIL stream_result%0d: rvalid=%b rdata=%0h want 1/%0h", k, rvalid, rdata, exp); end
      $display("txn stream %0d: rdata=%0h", k, rdata);
    end
    lvalid = '0;
    cycle();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL stream_drain: rvalid=%b want 0", rvalid); end
  endtask

  task automatic test_reset_mid();
    rready = 1'b0; ldata = rand_ops(); lvalid = '1;
    cycle();
    cycle();
    lvalid = '0;
    #1;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL rstmid_full: rvalid=%b want 1", rvalid); end
    rst = 1'b0;
    #1;
    total++; if (rvalid !== 1'b0 || rdata !== '0) begin bad++; $display("FAIL rstmid_async: rvalid=%b rdata=%0h want 0/0", rvalid, rdata); end
    rst = 1'b1;
    cycle();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rstmid_discard: rvalid=%b want 0", rvalid); end
    $display("txn reset_mid: buffer discarded");
  endtask

  task automatic test_saturate();
    ops_t o;
    logic [OWIDTH-1:0] want;
    do_reset();
    for (int i = 0; i < N_IN; i++) o[i] = WIDTH'(511);
    rready = 1'b1; ldata = o; lvalid = '1;
    #1;
    total++; if (sat_cnt !== 16'd0) begin bad++; $display("FAIL sat_start: sat_cnt=%0d want 0", sat_cnt); end
    cycle();
    lvalid = '0;
    #1;
    want = SAT_EN ? 12'd511 : 12'd2044;
    total++; if (rdata !== want) begin bad++; $display("FAIL sat_pos_rdata: got %0d want %0d", rdata, want); end
    total++; if (sat_cnt !== (SAT_EN ? 16'd1 : 16'd0)) begin bad++; $display("FAIL sat_pos_cnt: got %0d want %0d", sat_cnt, SAT_EN ? 1 : 0); end
    cycle();
    for (int i = 0; i < N_IN; i++) o[i] = WIDTH'(-512);
    ldata = o; lvalid = '1;
    cycle();
    lvalid = '0;
    #1;
    want = SAT_EN ? 12'hE00 : 12'h800;
    total++; if (rdata !== want) begin bad++; $display("FAIL sat_neg_rdata: got %0h want %0h", rdata, want); end
    total++; if (sat_cnt !== (SAT_EN ? 16'd2 : 16'd0)) begin bad++; $display("FAIL sat_neg_cnt: got %0d want %0d", sat_cnt, SAT_EN ? 2 : 0); end
    cycle();
    $display("txn saturate: sat_cnt=%0d", sat_cnt);
  endtask

  task automatic test_random_traffic();
    logic [OWIDTH-1:0] q[$];
    ops_t cur;
    bit   offering;
    bit   exp_fire;
    bit   exp_pop;
    int   sat_model;
    cycle();
    do_reset();
    offering = 1'b0;
    sat_model = 0;
    cur = '0;
    for (int k = 0; k < 300; k++) begin
      if (!offering && $urandom_range(0, 3) != 0) begin
        cur = rand_ops();
        offering = 1'b1;
      end
      ldata  = cur;
      lvalid = offering ? '1 : '0;
      rready = 1'($urandom_range(0, 1));
      #1;
      exp_fire = offering && (q.size() < 2);
      exp_pop  = (q.size() != 0) && rready;
      total++; if (lready !== {N_IN{exp_fire}}) begin bad++; $display("FAIL rand_lready%0d: got %b want %b", k, lready, {N_IN{exp_fire}}); end
      total++; if (rvalid !== (q.size() != 0)) begin bad++; $display("FAIL rand_rvalid%0d: got %b want %b", k, rvalid, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if (rdata !== q[0]) begin bad++; $display("FAIL rand_rdata%0d: got %0h want %0h", k, rdata, q[0]); end
      end
      total++; if (sat_cnt !== 16'(sat_model)) begin bad++; $display("FAIL rand_sat_cnt%0d: got %0d want %0d", k, sat_cnt, sat_model); end
      if (exp_pop) begin
        $display("txn random %0d: pop rdata=%0h", k, q[0]);
        void'(q.pop_front());
      end
      if (exp_fire) begin
        q.push_back(exp_rdata(cur));
        if (exp_sat(cur)) sat_model++;
        offering = 1'b0;
      end
      cycle();
    end
    lvalid = '0;
    rready = 1'b1;
    cycle();
    cycle();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rand_drain: rvalid=%b want 0", rvalid); end
  endtask

  initial begin
    rst    = 1'b0;
    lvalid = '0;
    rready = 1'b0;
    ldata  = '0;
    test_reset();
    test_basic();
    test_hold_channel();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_saturate();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
